mux2_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the shared 2:1 datapath mux and registers its output. Requester A and requester B each present a request and a data word. The block grants the mux to one requester at a time, bounds each tenure to `MAX_HOLD` cycles when the other side is waiting, and drives a registered, qualified output word downstream. It sits directly in front of the 2:1 mux leaf and replaces any free-running select source.

---
 rtl/mux2_arbiter_if.sv | 40 ++++
 rtl/mux2_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2_arbiter_if
// Request/grant and data bundle between the two requesters and the arbiter
// that owns the shared 2:1 datapath mux.
//
// Signals:
//   req_a, req_b     requests from A and B (held high until granted)
//   data_a, data_b   requester words, sampled while the matching grant is high
//   gnt_a, gnt_b     registered grants, never high together
//   sel              mux select, 1 routes A, 0 routes B (equals gnt_a)
//   data_out         registered mux output word
//   valid_out        data_out holds a granted word
//
// Modports:
//   master  requester/downstream side (drives requests and data)
//   slave   arbiter side (drives grants, select and output word)
// -----------------------------------------------------------------------------
interface mux2_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;

    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, data_out, valid_out
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, data_out, valid_out
    );
endinterface

// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
// Two-requester round-robin arbiter owning the select of the shared 2:1 mux.
// Grants one side at a time, bounds a tenure to MAX_HOLD cycles while the
// other side waits, and registers the selected word downstream.
//
// Parameters:
//   WIDTH     data word width
//   MAX_HOLD  max consecutive grant cycles under contention (1..255)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mux2_arbiter_if.slave (requests, data in, grants, sel, data out)
// -----------------------------------------------------------------------------
module mux2_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux2_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnA = 2'd1,
        StOwnB = 2'd2
    } state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_next;
    // 1 when B was granted most recently; A wins the next tie.
    logic             r_last_b;
    logic             w_last_b_next;
    logic             w_hold_done;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;

    assign w_hold_done = (r_hold_cnt == HoldLast);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.req_a && bus.req_b) begin
                    w_state_next = r_last_b ? StOwnA : StOwnB;
                end else if (bus.req_a) begin
                    w_state_next = StOwnA;
                end else if (bus.req_b) begin
                    w_state_next = StOwnB;
                end
            end
            StOwnA: begin
                if (!bus.req_a) begin
                    w_state_next = bus.req_b ? StOwnB : StIdle;
                end else if (bus.req_b && w_hold_done) begin
                    w_state_next = StOwnB;
                end
            end
            StOwnB: begin
                if (!bus.req_b) begin
                    w_state_next = bus.req_a ? StOwnA : StIdle;
                end else if (bus.req_a && w_hold_done) begin
                    w_state_next = StOwnA;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_hold_next   = r_hold_cnt;
        w_last_b_next = r_last_b;
        if (w_state_next != r_state) begin
            w_hold_next = 8'd0;
        end else if (r_state != StIdle && !w_hold_done) begin
            w_hold_next = r_hold_cnt + 8'd1;
        end
        if (w_state_next == StOwnA && r_state != StOwnA) begin
            w_last_b_next = 1'b0;
        end else if (w_state_next == StOwnB && r_state != StOwnB) begin
            w_last_b_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_hold_cnt <= 8'd0;
            r_last_b   <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_last_b   <= w_last_b_next;
        end
    end

    // Output word follows the grant held during the sampling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            if (r_state != StIdle) begin
                r_data_out <= (r_state == StOwnA) ? bus.data_a : bus.data_b;
            end
            r_valid_out <= (r_state != StIdle);
        end
    end

    assign bus.gnt_a     = (r_state == StOwnA);
    assign bus.gnt_b     = (r_state == StOwnB);
    assign bus.sel       = (r_state == StOwnA);
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
// Table of per-cycle stimulus with hand-derived grant expectations. Expected
// output words are pushed to a scoreboard when stimulus is driven (from the
// grant expected during that cycle) and popped after the sampling edge.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

    typedef struct {
        logic       rst_pre;
        logic       ra;
        logic       rb;
        logic [7:0] da;
        logic [7:0] db;
        logic       ea;
        logic       eb;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rst;

    mux2_arbiter_if #(.WIDTH(8)) u_if ();

    mux2_arbiter #(
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    exp_t sb[$];
    int   total;
    int   bad;
    logic exp_ga;
    logic exp_gb;
    logic [7:0] exp_hold;

    function automatic vec_t mk(logic r, logic a, logic b, logic [7:0] da, logic [7:0] db,
                                logic ea, logic eb);
        vec_t v;
        v.rst_pre = r;
        v.ra      = a;
        v.rb      = b;
        v.da      = da;
        v.db      = db;
        v.ea      = ea;
        v.eb      = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rst gnt_a"}, 32'(u_if.gnt_a), 32'd0);
        check({tag, " rst gnt_b"}, 32'(u_if.gnt_b), 32'd0);
        check({tag, " rst sel"}, 32'(u_if.sel), 32'd0);
        check({tag, " rst valid"}, 32'(u_if.valid_out), 32'd0);
        check({tag, " rst data"}, 32'(u_if.data_out), 32'd0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t  e;
        exp_t  got;
        string tag;
        tag = $sformatf("v%0d", idx);
        u_if.req_a  = v.ra;
        u_if.req_b  = v.rb;
        u_if.data_a = v.da;
        u_if.data_b = v.db;
        if (v.rst_pre) begin
            // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
            rst = 1'b1;
            #1;
            check_reset_outputs(tag);
            #1;
            rst      = 1'b0;
            exp_ga   = 1'b0;
            exp_gb   = 1'b0;
            exp_hold = 8'h00;
            sb.delete();
        end
        if (exp_ga) begin
            e.v = 1'b1;
            e.d = v.da;
        end else if (exp_gb) begin
            e.v = 1'b1;
            e.d = v.db;
        end else begin
            e.v = 1'b0;
            e.d = exp_hold;
        end
        exp_hold = e.d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check({tag, " gnt_a"}, 32'(u_if.gnt_a), 32'(v.ea));
        check({tag, " gnt_b"}, 32'(u_if.gnt_b), 32'(v.eb));
        check({tag, " sel"}, 32'(u_if.sel), 32'(v.ea));
        got = sb.pop_front();
        check({tag, " valid"}, 32'(u_if.valid_out), 32'(got.v));
        check({tag, " data"}, 32'(u_if.data_out), 32'(got.d));
        exp_ga = v.ea;
        exp_gb = v.eb;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        exp_ga      = 1'b0;
        exp_gb      = 1'b0;
        exp_hold    = 8'h00;
        rst         = 1'b0;
        u_if.req_a  = 1'b0;
        u_if.req_b  = 1'b0;
        u_if.data_a = 8'h00;
        u_if.data_b = 8'h00;

        // rst, ra, rb, da, db, exp gnt_a, exp gnt_b
        // Solo A: holds past MAX_HOLD with B idle, words 11..16.
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h11, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h12, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h13, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h14, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h15, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h16, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
        // B solo, idle, then tie -> A (last is B).
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h21, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h22, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h31, 8'h41, 1, 0));
        // Contention: A4, B4, then A.
        tbl.push_back(mk(0, 1, 1, 8'h32, 8'h42, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h33, 8'h43, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h34, 8'h44, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h35, 8'h45, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h36, 8'h46, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h37, 8'h47, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h38, 8'h48, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h39, 8'h49, 1, 0));
        // A releases in tenure cycle 2: zero-bubble handover to B.
        tbl.push_back(mk(0, 1, 1, 8'h3a, 8'h4a, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h3b, 8'h4b, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h3c, 8'h4c, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h3d, 8'h4d, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
        // A owns (last=A), reset mid-tenure, tie afterwards must go to A.
        tbl.push_back(mk(0, 1, 0, 8'h50, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 1, 8'h55, 8'h65, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h56, 8'h66, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h57, 8'h67, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h58, 8'h68, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h59, 8'h69, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h5a, 8'h6a, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h5b, 8'h6b, 0, 1));
        // Reset during B's third tenure cycle, both requesting -> A first.
        tbl.push_back(mk(1, 1, 1, 8'h5c, 8'h6c, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h5d, 8'h6d, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h5e, 8'h6e, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));

        // Power-on reset, asynchronous, before any clock edge.
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        check_reset_outputs("por held");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
